llc_snoop_responder: RTL and testbench
======================================

LLC_SNOOP_RESPONDER -- requirements
Module: llc_snoop_responder

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is asynchronous and active-high.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 bus_valid  in  1  snooped bus operation present; bus_op  in  3  READ=1/WRITE=2/INVALIDATE=3/RWIM=4; bus_addr  in  32.
REQ-005 bus_ready  out  1  high only in IDLE; an op is accepted on bus_valid&&bus_ready.
REQ-006 lk_req  out  1; lk_index  out  15 (addr[20:6]); lk_tag  out  11 (addr[31:21]); lk_hit  in  1; lk_way  in  3; lk_mesi  in  2. The lookup answer is combinational in the lk_req cycle.
REQ-007 upd_en  out  1; upd_index  out  15; upd_way  out  3; upd_mesi  out  2; a one-cycle MESI write to the LLC tag store.
REQ-008 snoop_valid  out  1; snoop_result  out  2 (NOHIT=0/HIT=1/HITM=2).
REQ-009 msg_valid  out  1; msg_type  out  3 (GETLINE=1/INVALIDATELINE=3); msg_addr  out  32; msg_ready  in  1.
REQ-010 wb_req  out  1; wb_addr  out  32 (offset bits zeroed); wb_ack  in  1; this is the bus WRITE flush of a modified line.
REQ-011 snoop_cnt, hitm_cnt  out  16 each; these are saturating statistics counters.

Function
REQ-012 MESI encoding SHALL be M=00, E=01, S=10, I=11; a miss (lk_hit=0) SHALL be treated as I.
REQ-013 FSM states SHALL be IDLE, LOOKUP, RESP, GETLINE, WRBACK, INVAL, UPDATE.
REQ-014 IDLE: on accept, latch op/addr and go to LOOKUP; bus_valid with bus_ready low SHALL be ignored (no queueing).
REQ-015 LOOKUP: drive lk_req=1 for exactly one cycle, register lk_hit/lk_way/lk_mesi, and go to RESP.
REQ-016 RESP: snoop_valid=1 for exactly one cycle, 2 cycles after the accept edge; snoop_result SHALL be HITM if the pre-state is M, HIT if E or S, and NOHIT if I. For a WRITE op the result SHALL always be NOHIT.
REQ-017 READ: M goes to GETLINE, then WRBACK, then UPDATE(S); E goes to UPDATE(S); S and I go directly to IDLE with no update.
REQ-018 RWIM: M goes to GETLINE, then WRBACK, then INVAL, then UPDATE(I); E or S goes to INVAL, then UPDATE(I); I goes to IDLE.
REQ-019 INVALIDATE: S goes to INVAL, then UPDATE(I); E or M (a protocol violation) SHALL be handled like S; I goes to IDLE.
REQ-020 WRITE: no state change and no messages; go from RESP to IDLE.
REQ-021 GETLINE/INVAL: hold msg_valid with stable msg_type/msg_addr until msg_ready; advance on the handshake cycle.
REQ-022 WRBACK: hold wb_req until wb_ack; wb_ack received outside WRBACK SHALL be ignored.
REQ-023 UPDATE: upd_en=1 for one cycle with the registered way, then go to IDLE; after UPDATE, bus_ready SHALL be high the next cycle.
REQ-024 snoop_cnt SHALL increment at each RESP; hitm_cnt SHALL increment at each RESP that returns HITM; both SHALL hold at 0xFFFF.
REQ-025 Minimum occupancy is 3 cycles (accept, LOOKUP, RESP); a back-to-back accept SHALL occur on the cycle after the return to IDLE.

Reset
REQ-026 Reset asserted in any state SHALL force IDLE; all pulses, requests and counters SHALL go to 0, with bus_ready=1 after release.
REQ-027 A reset mid-operation SHALL abandon the operation with no upd_en, and no msg_valid or wb_req SHALL be held.

Structure
REQ-028 The MESI, bus-op, snoop-result and message-type enums SHALL reside in the shared package cache_Defs, alongside the tag/index/offset widths.
REQ-029 Pre-state plus op to {result, needs_getline, needs_wb, needs_inval, next_mesi} SHALL be a combinational sub-module mesi_snoop_xlate.

Verification
REQ-030 READ 0x0020_0040, lookup hit with E -> snoop_result=HIT at accept+2, upd_mesi=10, no msg, no wb.
REQ-031 RWIM 0x0040_0080, hit with M, msg_ready delayed 3 cycles, wb_ack delayed 2 cycles -> HITM, GETLINE, wb_addr=0x0040_0080, INVALIDATELINE, upd_mesi=11, hitm_cnt=1.
REQ-032 INVALIDATE, lookup miss -> NOHIT, no upd_en, bus_ready high at accept+3.
REQ-033 WRITE, hit with M -> NOHIT, no upd_en, no msg.
REQ-034 Reset asserted during WRBACK -> wb_req=0 immediately, no upd_en, snoop_cnt=0, IDLE.
REQ-035 65,540 READ misses back-to-back -> snoop_cnt saturates at 0xFFFF, hitm_cnt=0.

Source files
------------

// File: rtl/llc_snoop_responder_pkg.sv
// Shared cache definitions for the LLC snoop path: address field widths,
// MESI / bus-op / snoop-result / message enums and address helpers.
package cache_Defs;

  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 6;
  localparam int INDEX_W  = 15;
  localparam int TAG_W    = 11;
  localparam int WAY_W    = 3;
  localparam int CNT_W    = 16;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

  typedef enum logic [1:0] {
    MESI_M = 2'b00,
    MESI_E = 2'b01,
    MESI_S = 2'b10,
    MESI_I = 2'b11
  } mesi_e;

  typedef enum logic [2:0] {
    OP_NONE       = 3'd0,
    OP_READ       = 3'd1,
    OP_WRITE      = 3'd2,
    OP_INVALIDATE = 3'd3,
    OP_RWIM       = 3'd4
  } bus_op_e;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2
  } snoop_res_e;

  typedef enum logic [2:0] {
    MSG_NONE           = 3'd0,
    MSG_GETLINE        = 3'd1,
    MSG_INVALIDATELINE = 3'd3
  } msg_type_e;

  function automatic logic [INDEX_W-1:0] index_of(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return a & LINE_MASK;
  endfunction

endpackage

// File: rtl/llc_snoop_responder_if.sv
// Snoop responder signal bundle: snooped bus, tag lookup/update, coherence
// messages, write-back flush and statistics.
interface llc_snoop_responder_if;
  import cache_Defs::*;

  logic                bus_valid;
  logic [2:0]          bus_op;
  logic [ADDR_W-1:0]   bus_addr;
  logic                bus_ready;

  logic                lk_req;
  logic [INDEX_W-1:0]  lk_index;
  logic [TAG_W-1:0]    lk_tag;
  logic                lk_hit;
  logic [WAY_W-1:0]    lk_way;
  logic [1:0]          lk_mesi;

  logic                upd_en;
  logic [INDEX_W-1:0]  upd_index;
  logic [WAY_W-1:0]    upd_way;
  logic [1:0]          upd_mesi;

  logic                snoop_valid;
  logic [1:0]          snoop_result;

  logic                msg_valid;
  logic [2:0]          msg_type;
  logic [ADDR_W-1:0]   msg_addr;
  logic                msg_ready;

  logic                wb_req;
  logic [ADDR_W-1:0]   wb_addr;
  logic                wb_ack;

  logic [CNT_W-1:0]    snoop_cnt;
  logic [CNT_W-1:0]    hitm_cnt;

  modport slave (
    input  bus_valid, bus_op, bus_addr, lk_hit, lk_way, lk_mesi, msg_ready, wb_ack,
    output bus_ready, lk_req, lk_index, lk_tag, upd_en, upd_index, upd_way, upd_mesi,
           snoop_valid, snoop_result, msg_valid, msg_type, msg_addr, wb_req, wb_addr,
           snoop_cnt, hitm_cnt
  );

  modport master (
    output bus_valid, bus_op, bus_addr, lk_hit, lk_way, lk_mesi, msg_ready, wb_ack,
    input  bus_ready, lk_req, lk_index, lk_tag, upd_en, upd_index, upd_way, upd_mesi,
           snoop_valid, snoop_result, msg_valid, msg_type, msg_addr, wb_req, wb_addr,
           snoop_cnt, hitm_cnt
  );

endinterface

// File: rtl/llc_snoop_responder_xlate.sv
// Combinational MESI snoop translation: pre-state and bus op to snoop result,
// the actions the line needs, and the state it ends in.
module mesi_snoop_xlate
  import cache_Defs::*;
(
  input  mesi_e      pre_mesi,
  input  logic [2:0] op,
  output snoop_res_e result,
  output logic       needs_getline,
  output logic       needs_wb,
  output logic       needs_inval,
  output mesi_e      next_mesi
);

  always_comb begin
    needs_getline = 1'b0;
    needs_wb      = 1'b0;
    needs_inval   = 1'b0;
    next_mesi     = pre_mesi;
    case (pre_mesi)
      MESI_M:  result = SNP_HITM;
      MESI_I:  result = SNP_NOHIT;
      default: result = SNP_HIT;
    endcase

    case (op)
      OP_READ: begin
        if (pre_mesi == MESI_M) begin
          needs_getline = 1'b1;
          needs_wb      = 1'b1;
          next_mesi     = MESI_S;
        end else if (pre_mesi == MESI_E) begin
          next_mesi     = MESI_S;
        end
      end
      OP_RWIM: begin
        if (pre_mesi == MESI_M) begin
          needs_getline = 1'b1;
          needs_wb      = 1'b1;
          needs_inval   = 1'b1;
          next_mesi     = MESI_I;
        end else if (pre_mesi != MESI_I) begin
          needs_inval   = 1'b1;
          next_mesi     = MESI_I;
        end
      end
      // E or M here is a protocol violation; the line is dropped like S.
      OP_INVALIDATE: begin
        if (pre_mesi != MESI_I) begin
          needs_inval   = 1'b1;
          next_mesi     = MESI_I;
        end
      end
      default: result = SNP_NOHIT;
    endcase
  end

endmodule

// File: rtl/llc_snoop_responder.sv
// LLC snoop responder: accepts one snooped bus op at a time, looks up the tag
// store, answers the snoop and walks the line through flush/invalidate/update.
module llc_snoop_responder
  import cache_Defs::*;
#(
  parameter logic [CNT_W-1:0] CNT_SAT = '1
) (
  input logic                  clk,
  input logic                  rst,
  llc_snoop_responder_if.slave sif
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, RESP, GETLINE, WRBACK, INVAL, UPDATE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              hit_p1;
  logic [WAY_W-1:0]  way_p1;
  mesi_e             mesi_p1;
  logic [CNT_W-1:0]  snoop_cnt_q, hitm_cnt_q;

  mesi_e             pre_mesi, next_mesi;
  snoop_res_e        result;
  logic              needs_getline, needs_wb, needs_inval, needs_upd;
  logic              accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_SAT) ? CNT_SAT : v + 1'b1;
  endfunction

  assign accept    = sif.bus_valid && (state_q == IDLE);
  assign pre_mesi  = hit_p1 ? mesi_p1 : MESI_I;
  assign needs_upd = (next_mesi != pre_mesi);

  mesi_snoop_xlate u_xlate (
    .pre_mesi      (pre_mesi),
    .op            (op_p0),
    .result        (result),
    .needs_getline (needs_getline),
    .needs_wb      (needs_wb),
    .needs_inval   (needs_inval),
    .next_mesi     (next_mesi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Stage p0: op/address captured on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0   <= sif.bus_op;
      addr_p0 <= sif.bus_addr;
    end
  end

  // Stage p1: lookup answer captured in the single LOOKUP cycle
  always_ff @(posedge clk) begin
    if (state_q == LOOKUP) begin
      hit_p1  <= sif.lk_hit;
      way_p1  <= sif.lk_way;
      mesi_p1 <= mesi_e'(sif.lk_mesi);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snoop_cnt_q <= '0;
      hitm_cnt_q  <= '0;
    end else if (state_q == RESP) begin
      snoop_cnt_q <= sat_inc(snoop_cnt_q);
      if (result == SNP_HITM) hitm_cnt_q <= sat_inc(hitm_cnt_q);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sif.bus_valid) state_d = LOOKUP;
      LOOKUP:  state_d = RESP;
      RESP: begin
        if (needs_getline)    state_d = GETLINE;
        else if (needs_inval) state_d = INVAL;
        else if (needs_upd)   state_d = UPDATE;
        else                  state_d = IDLE;
      end
      GETLINE: if (sif.msg_ready) state_d = needs_wb ? WRBACK : (needs_inval ? INVAL : UPDATE);
      WRBACK:  if (sif.wb_ack)    state_d = needs_inval ? INVAL : UPDATE;
      INVAL:   if (sif.msg_ready) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sif.bus_ready    = (state_q == IDLE);
  assign sif.lk_req       = (state_q == LOOKUP);
  assign sif.lk_index     = index_of(addr_p0);
  assign sif.lk_tag       = tag_of(addr_p0);

  assign sif.snoop_valid  = (state_q == RESP);
  assign sif.snoop_result = result;

  assign sif.msg_valid    = (state_q == GETLINE) || (state_q == INVAL);
  assign sif.msg_type     = (state_q == INVAL) ? MSG_INVALIDATELINE : MSG_GETLINE;
  assign sif.msg_addr     = line_addr(addr_p0);

  assign sif.wb_req       = (state_q == WRBACK);
  assign sif.wb_addr      = line_addr(addr_p0);

  assign sif.upd_en       = (state_q == UPDATE);
  assign sif.upd_index    = index_of(addr_p0);
  assign sif.upd_way      = way_p1;
  assign sif.upd_mesi     = next_mesi;

  assign sif.snoop_cnt    = snoop_cnt_q;
  assign sif.hitm_cnt     = hitm_cnt_q;

endmodule

// File: tb/tb_llc_snoop_responder.sv
// Bench for llc_snoop_responder: directed vector table, randomized ops against
// a rule-level model, reset during write-back and counter saturation.
module tb_llc_snoop_responder;
  import cache_Defs::*;

  localparam logic [15:0] SAT = 16'h0FFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  llc_snoop_responder_if sif();
  llc_snoop_responder #(.CNT_SAT(SAT)) dut (.clk(clk), .rst(rst), .sif(sif));

  int checks   = 0;
  int failures = 0;
  int exp_snoop = 0;
  int exp_hitm  = 0;

  typedef struct {
    int       result;
    bit       getline, wb, inval, upd;
    int       umesi;
  } exp_t;

  typedef struct {
    int          op;
    logic [31:0] addr;
    bit          hit;
    int          way;
    int          mesi;
    int          mdly, wdly;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mkexp(int r, bit g, bit w, bit i, bit u, int um);
    exp_t e;
    e.result = r; e.getline = g; e.wb = w; e.inval = i; e.upd = u; e.umesi = um;
    return e;
  endfunction

  function automatic vec_t mk(int op, logic [31:0] addr, bit hit, int way, int mesi,
                              int md, int wd, exp_t e);
    vec_t v;
    v.op = op; v.addr = addr; v.hit = hit; v.way = way; v.mesi = mesi;
    v.mdly = md; v.wdly = wd; v.e = e;
    return v;
  endfunction

  // Protocol rules: M=0 E=1 S=2 I=3; ops READ=1 WRITE=2 INVALIDATE=3 RWIM=4
  function automatic exp_t model(int op, bit hit, int mesi);
    int   pre;
    exp_t e;
    pre = hit ? mesi : 3;
    e = mkexp(0, 0, 0, 0, 0, 0);
    if (op == 2)        e.result = 0;
    else if (pre == 0)  e.result = 2;
    else if (pre == 3)  e.result = 0;
    else                e.result = 1;
    if (op == 1 && pre == 0)      e = mkexp(e.result, 1, 1, 0, 1, 2);
    else if (op == 1 && pre == 1) e = mkexp(e.result, 0, 0, 0, 1, 2);
    else if (op == 4 && pre == 0) e = mkexp(e.result, 1, 1, 1, 1, 3);
    else if (op == 4 && pre != 3) e = mkexp(e.result, 0, 0, 1, 1, 3);
    else if (op == 3 && pre != 3) e = mkexp(e.result, 0, 0, 1, 1, 3);
    return e;
  endfunction

  // Starts on a falling edge with the DUT idle; returns on the falling edge
  // where bus_ready is seen again.
  task automatic run_op(input vec_t v, input string tag);
    int nsnoop = 0, snoop_c = -1, nlk = 0, nmsg = 0, nwb = 0, nupd = 0;
    int mwait = 0, wwait = 0, end_c = -1, exp_end, mi;
    int res = 0, um = 0, uw = 0, ui = 0;
    logic [31:0] wba = '0, hold_a = '0, line;
    logic [2:0]  hold_t = '0;
    logic [2:0]  mt [2];
    logic [31:0] ma [2];
    bit lk_ok = 1, stable = 1, holding = 0;
    mt[0] = '0; mt[1] = '0; ma[0] = '0; ma[1] = '0;
    line = {v.addr[31:6], 6'b0};

    chk({tag, ".ready_at_accept"}, sif.bus_ready, 1);
    sif.bus_valid = 1'b1;
    sif.bus_op    = v.op[2:0];
    sif.bus_addr  = v.addr;
    sif.lk_hit    = v.hit;
    sif.lk_way    = v.way[2:0];
    sif.lk_mesi   = v.mesi[1:0];
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      sif.bus_valid = 1'b0;
      sif.msg_ready = 1'b0;
      sif.wb_ack    = 1'b0;
      if (sif.lk_req) begin
        nlk++;
        if (c != 1 || sif.lk_index !== v.addr[20:6] || sif.lk_tag !== v.addr[31:21]) lk_ok = 0;
      end
      if (sif.snoop_valid) begin
        nsnoop++; snoop_c = c; res = int'(sif.snoop_result);
      end
      if (sif.msg_valid) begin
        if (holding && (sif.msg_type !== hold_t || sif.msg_addr !== hold_a)) stable = 0;
        hold_t = sif.msg_type; hold_a = sif.msg_addr; holding = 1;
        if (mwait == v.mdly) begin
          sif.msg_ready = 1'b1;
          if (nmsg < 2) begin mt[nmsg] = sif.msg_type; ma[nmsg] = sif.msg_addr; end
          nmsg++; mwait = 0; holding = 0;
        end else mwait++;
      end else sif.msg_ready = 1'($urandom_range(0, 1));
      if (sif.wb_req) begin
        if (wwait == v.wdly) begin
          sif.wb_ack = 1'b1; nwb++; wba = sif.wb_addr; wwait = 0;
        end else wwait++;
      end else sif.wb_ack = 1'($urandom_range(0, 1));
      if (sif.upd_en) begin
        nupd++; um = int'(sif.upd_mesi); uw = int'(sif.upd_way); ui = int'(sif.upd_index);
      end
      if (sif.bus_ready) begin end_c = c; break; end
    end
    sif.msg_ready = 1'b0;
    sif.wb_ack    = 1'b0;

    exp_end = 3 + (v.e.getline ? v.mdly + 1 : 0) + (v.e.wb ? v.wdly + 1 : 0)
                + (v.e.inval ? v.mdly + 1 : 0) + (v.e.upd ? 1 : 0);
    chk({tag, ".snoop_cycle"}, snoop_c, 2);
    chk({tag, ".snoop_pulses"}, nsnoop, 1);
    chk({tag, ".snoop_result"}, res, v.e.result);
    chk({tag, ".lk_req_pulses"}, nlk, 1);
    chk({tag, ".lk_fields"}, lk_ok, 1);
    chk({tag, ".msg_count"}, nmsg, int'(v.e.getline) + int'(v.e.inval));
    chk({tag, ".msg_stable"}, stable, 1);
    mi = 0;
    if (v.e.getline) begin
      chk({tag, ".getline_type"}, mt[0], 1);
      chk({tag, ".getline_addr"}, ma[0], line);
      mi = 1;
    end
    if (v.e.inval) begin
      chk({tag, ".inval_type"}, mt[mi], 3);
      chk({tag, ".inval_addr"}, ma[mi], line);
    end
    chk({tag, ".wb_count"}, nwb, int'(v.e.wb));
    if (v.e.wb) chk({tag, ".wb_addr"}, wba, line);
    chk({tag, ".upd_count"}, nupd, int'(v.e.upd));
    if (v.e.upd) begin
      chk({tag, ".upd_mesi"}, um, v.e.umesi);
      chk({tag, ".upd_way"}, uw, v.way);
      chk({tag, ".upd_index"}, ui, int'(v.addr[20:6]));
    end
    chk({tag, ".ready_cycle"}, end_c, exp_end);

    exp_snoop = (exp_snoop >= int'(SAT)) ? int'(SAT) : exp_snoop + 1;
    if (v.e.result == 2) exp_hitm = (exp_hitm >= int'(SAT)) ? int'(SAT) : exp_hitm + 1;
    chk({tag, ".snoop_cnt"}, sif.snoop_cnt, exp_snoop);
    chk({tag, ".hitm_cnt"}, sif.hitm_cnt, exp_hitm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [10];
    vec_t rv;
    int   acc, sv, bad;
    bit   seen;

    sif.bus_valid = 1'b0; sif.bus_op = '0; sif.bus_addr = '0;
    sif.lk_hit = 1'b0; sif.lk_way = '0; sif.lk_mesi = 2'b11;
    sif.msg_ready = 1'b0; sif.wb_ack = 1'b0;

    tbl[0] = mk(1, 32'h0020_0040, 1, 5, 1, 0, 0, mkexp(1, 0, 0, 0, 1, 2));
    tbl[1] = mk(4, 32'h0040_0080, 1, 2, 0, 3, 2, mkexp(2, 1, 1, 1, 1, 3));
    tbl[2] = mk(3, 32'h1234_5678, 0, 0, 2, 0, 0, mkexp(0, 0, 0, 0, 0, 0));
    tbl[3] = mk(2, 32'h0000_1000, 1, 1, 0, 0, 0, mkexp(0, 0, 0, 0, 0, 0));
    tbl[4] = mk(1, 32'hDEAD_BEC0, 1, 7, 0, 0, 0, mkexp(2, 1, 1, 0, 1, 2));
    tbl[5] = mk(1, 32'h0001_0000, 1, 3, 2, 0, 0, mkexp(1, 0, 0, 0, 0, 0));
    tbl[6] = mk(3, 32'h00FF_FFC0, 1, 4, 1, 1, 0, mkexp(1, 0, 0, 1, 1, 3));
    tbl[7] = mk(4, 32'hFFFF_FFFF, 1, 6, 2, 0, 0, mkexp(1, 0, 0, 1, 1, 3));
    tbl[8] = mk(4, 32'h8000_0040, 0, 1, 0, 0, 0, mkexp(0, 0, 0, 0, 0, 0));
    tbl[9] = mk(3, 32'h0ABC_DE40, 1, 0, 0, 2, 0, mkexp(2, 0, 0, 1, 1, 3));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.bus_ready", sif.bus_ready, 1);
    chk("reset.snoop_cnt", sif.snoop_cnt, 0);
    chk("reset.hitm_cnt", sif.hitm_cnt, 0);
    chk("reset.pulses", {sif.upd_en, sif.msg_valid, sif.wb_req, sif.snoop_valid, sif.lk_req}, 0);

    for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 150; i++) begin
      rv.op   = $urandom_range(1, 4);
      rv.addr = $urandom;
      rv.hit  = 1'($urandom_range(0, 1));
      rv.way  = $urandom_range(0, 7);
      rv.mesi = $urandom_range(0, 3);
      rv.mdly = $urandom_range(0, 3);
      rv.wdly = $urandom_range(0, 3);
      rv.e    = model(rv.op, rv.hit, rv.mesi);
      run_op(rv, $sformatf("rnd%0d", i));
    end

    // Reset while the write-back of a modified line is pending
    chk("rstwb.ready", sif.bus_ready, 1);
    sif.bus_valid = 1'b1; sif.bus_op = 3'd1; sif.bus_addr = 32'h0030_00C0;
    sif.lk_hit = 1'b1; sif.lk_way = 3'd2; sif.lk_mesi = 2'b00;
    sif.msg_ready = 1'b1; sif.wb_ack = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      sif.bus_valid = 1'b0;
      if (sif.wb_req) begin seen = 1; break; end
    end
    chk("rstwb.reached_wrback", seen, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstwb.wb_req_dropped", sif.wb_req, 0);
    chk("rstwb.snoop_cnt", sif.snoop_cnt, 0);
    chk("rstwb.hitm_cnt", sif.hitm_cnt, 0);
    chk("rstwb.no_upd", sif.upd_en, 0);
    @(negedge clk);
    rst = 1'b0;
    sif.msg_ready = 1'b0;
    exp_snoop = 0; exp_hitm = 0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (sif.upd_en || sif.msg_valid || sif.wb_req || !sif.bus_ready) bad++;
    end
    chk("rstwb.idle_after", bad, 0);

    // Back-to-back READ misses past the saturation point
    acc = 0; sv = 0;
    sif.bus_valid = 1'b1; sif.bus_op = 3'd1; sif.lk_hit = 1'b0;
    for (int k = 0; k < 3 * (int'(SAT) + 5); k++) begin
      sif.bus_addr = $urandom;
      if (sif.bus_ready) acc++;
      if (sif.snoop_valid) sv++;
      @(negedge clk);
    end
    sif.bus_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat.accepts", acc, int'(SAT) + 5);
    chk("sat.snoop_pulses", sv, int'(SAT) + 5);
    chk("sat.snoop_cnt", sif.snoop_cnt, SAT);
    chk("sat.hitm_cnt", sif.hitm_cnt, 0);
    chk("sat.ready", sif.bus_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
